// File: rtl/fp_mul_round_stage_pkg.sv
// fp_mul_pkg: shared types and constants for the FP32 multiplier datapath.
//   r_mode_e : IEEE rounding-mode encoding carried on r_mode.
//   norm_t   : normalize-stage register (stage 1 -> stage 2 payload).
package fp_mul_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } r_mode_e;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [30:0] FP32_MAXF = 31'h7F7F_FFFF;
    localparam logic [7:0]  EXP_MAX   = 8'hFE;

    // Internal exponent width: wide enough for exp_sum+1 plus a rounding
    // carry without wrapping, and signed so underflow stays negative.
    localparam int NORM_E_W = 12;

    typedef struct packed {
        logic                       sign;
        logic signed [NORM_E_W-1:0] e;
        logic [22:0]                man;
        logic                       g;
        logic                       st;
        logic [2:0]                 r_mode;
        logic                       nan;
        logic                       inf;
        logic                       zero;
    } norm_t;

endpackage

// File: rtl/fp_mul_round_stage_if.sv
// fp_mul_round_stage_if: handshake bundle for the multiplier round stage.
//   Input side : in_valid/in_ready plus beat payload (sign_Z, exp_sum,
//                frc_Z_full, r_mode, is_nan/is_inf/is_zero).
//   Output side: out_valid/out_ready plus result (fp_Z, ovrf, udrf).
//   master = producer/consumer environment, slave = the round stage.
interface fp_mul_round_stage_if #(
    parameter int EXP_W = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    sign_Z;
    logic signed [EXP_W-1:0] exp_sum;
    logic [47:0]             frc_Z_full;
    logic [2:0]              r_mode;
    logic                    is_nan;
    logic                    is_inf;
    logic                    is_zero;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             fp_Z;
    logic                    ovrf;
    logic                    udrf;

    modport master (
        output in_valid, sign_Z, exp_sum, frc_Z_full, r_mode,
               is_nan, is_inf, is_zero, out_ready,
        input  in_ready, out_valid, fp_Z, ovrf, udrf
    );

    modport slave (
        input  in_valid, sign_Z, exp_sum, frc_Z_full, r_mode,
               is_nan, is_inf, is_zero, out_ready,
        output in_ready, out_valid, fp_Z, ovrf, udrf
    );
endinterface

// File: rtl/fp_mul_round_stage_round_inc.sv
// fp_round_inc: combinational round-increment decision, shared with the
// adder datapath.
//   r_mode_i : rounding mode (unknown encodings behave as RNE)
//   sign_i   : result sign
//   lsb_i    : mantissa LSB (tie-break for RNE)
//   g_i/st_i : guard and sticky bits
//   inc_o    : add one ulp to the mantissa
module fp_round_inc
    import fp_mul_pkg::*;
(
    input  logic [2:0] r_mode_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       g_i,
    input  logic       st_i,
    output logic       inc_o
);
    always_comb begin
        inc_o = 1'b0;
        case (r_mode_e'(r_mode_i))
            RTZ:     inc_o = 1'b0;
            RDN:     inc_o = (g_i | st_i) & sign_i;
            RUP:     inc_o = (g_i | st_i) & ~sign_i;
            RMM:     inc_o = g_i;
            default: inc_o = g_i & (st_i | lsb_i);
        endcase
    end
endmodule

// File: rtl/fp_mul_round_stage.sv
// fp_mul_round_stage: normalize + round stage of the FP32 multiplier.
// Two pipeline registers (normalize, round) with valid/ready on both sides;
// subnormal results flush to signed zero.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of fp_mul_round_stage_if (input beat, result)
module fp_mul_round_stage
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 10,
    parameter int BIAS  = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_mul_round_stage_if.slave  bus
);
    localparam logic signed [NORM_E_W-1:0] E_OVF = NORM_E_W'(2 * BIAS + 1);

    logic        s1_valid_q, s2_valid_q;
    norm_t       norm_d, s1_q;
    logic        s1_adv, s2_adv;
    logic [31:0] fp_z_q, fp_z_d;
    logic        ovrf_q, ovrf_d, udrf_q, udrf_d;
    logic        inc, carry;
    logic [22:0] m_rnd;
    logic signed [NORM_E_W-1:0] e_ext, e_rnd;

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = s2_valid_q;
    assign bus.fp_Z      = fp_z_q;
    assign bus.ovrf      = ovrf_q;
    assign bus.udrf      = udrf_q;

    assign e_ext = {{(NORM_E_W - EXP_W){bus.exp_sum[EXP_W-1]}}, bus.exp_sum};

    // Stage 1: align the 48-bit product so the leading one sits at bit 47.
    always_comb begin
        norm_d        = '0;
        norm_d.sign   = bus.sign_Z;
        norm_d.r_mode = bus.r_mode;
        norm_d.nan    = bus.is_nan;
        norm_d.inf    = bus.is_inf;
        norm_d.zero   = bus.is_zero;
        if (bus.frc_Z_full[47]) begin
            norm_d.man = bus.frc_Z_full[46:24];
            norm_d.g   = bus.frc_Z_full[23];
            norm_d.st  = |bus.frc_Z_full[22:0];
            norm_d.e   = e_ext + NORM_E_W'(1);
        end else begin
            norm_d.man = bus.frc_Z_full[45:23];
            norm_d.g   = bus.frc_Z_full[22];
            norm_d.st  = |bus.frc_Z_full[21:0];
            norm_d.e   = e_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= norm_d;
            end
        end
    end

    // Stage 2: round, then classify.
    fp_round_inc u_round_inc (
        .r_mode_i (s1_q.r_mode),
        .sign_i   (s1_q.sign),
        .lsb_i    (s1_q.man[0]),
        .g_i      (s1_q.g),
        .st_i     (s1_q.st),
        .inc_o    (inc)
    );

    // A mantissa carry-out leaves m_rnd at zero, i.e. 1.0 x 2^(e+1).
    assign {carry, m_rnd} = {1'b0, s1_q.man} + {23'b0, inc};
    assign e_rnd          = carry ? s1_q.e + NORM_E_W'(1) : s1_q.e;

    always_comb begin
        fp_z_d = '0;
        ovrf_d = 1'b0;
        udrf_d = 1'b0;
        if (s1_q.nan) begin
            fp_z_d = FP32_QNAN;
        end else if (s1_q.inf) begin
            fp_z_d = {s1_q.sign, 8'hFF, 23'b0};
        end else if (s1_q.zero) begin
            fp_z_d = {s1_q.sign, 31'b0};
        end else if (!e_rnd[NORM_E_W-1] && e_rnd >= E_OVF) begin
            ovrf_d = 1'b1;
            case (r_mode_e'(s1_q.r_mode))
                RTZ:     fp_z_d = {s1_q.sign, FP32_MAXF};
                RDN:     fp_z_d = s1_q.sign ? {1'b1, 8'hFF, 23'b0} : {1'b0, FP32_MAXF};
                RUP:     fp_z_d = s1_q.sign ? {1'b1, FP32_MAXF} : {1'b0, 8'hFF, 23'b0};
                default: fp_z_d = {s1_q.sign, 8'hFF, 23'b0};
            endcase
        end else if (e_rnd[NORM_E_W-1] || e_rnd == '0) begin
            fp_z_d = {s1_q.sign, 31'b0};
            udrf_d = 1'b1;
        end else begin
            fp_z_d = {s1_q.sign, e_rnd[7:0], m_rnd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            fp_z_q     <= '0;
            ovrf_q     <= 1'b0;
            udrf_q     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                fp_z_q <= fp_z_d;
                ovrf_q <= ovrf_d;
                udrf_q <= udrf_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Directed testbench for fp_mul_round_stage.
module tb_fp_mul_round_stage;
    import fp_mul_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_round_stage_if #(.EXP_W(10)) bus ();

    fp_mul_round_stage #(.EXP_W(10), .BIAS(127)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        sign;
        logic [9:0]  es;
        logic [47:0] frc;
        logic [2:0]  md;
        logic        nan, inf, zero;
        logic [31:0] fp;
        logic        ov, ud;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sign, input logic [9:0] es, input logic [47:0] frc,
                                input logic [2:0] md, input logic nan, input logic inf,
                                input logic zero, input logic [31:0] fp, input logic ov,
                                input logic ud);
        vec_t v;
        v.sign = sign; v.es = es; v.frc = frc; v.md = md;
        v.nan = nan; v.inf = inf; v.zero = zero;
        v.fp = fp; v.ov = ov; v.ud = ud;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.sign_Z     = v.sign;
        bus.exp_sum    = v.es;
        bus.frc_Z_full = v.frc;
        bus.r_mode     = v.md;
        bus.is_nan     = v.nan;
        bus.is_inf     = v.inf;
        bus.is_zero    = v.zero;
    endtask

    task automatic do_beat(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        drive(v);
        bus.in_valid = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", idx), bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 10);
        chk($sformatf("v%0d_latency", idx), n, 2);
        chk($sformatf("v%0d_fp_Z", idx), bus.fp_Z, v.fp);
        chk($sformatf("v%0d_ovrf", idx), bus.ovrf, v.ov);
        chk($sformatf("v%0d_udrf", idx), bus.udrf, v.ud);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bp[4];
        int   acc, recv, seen;

        // sign, exp_sum, frc, mode, nan, inf, zero, fp_Z, ovrf, udrf
        vecs.push_back(mk(0, 10'd127, 48'h900000000000, RNE, 0, 0, 0, 32'h40100000, 0, 0)); // 0
        vecs.push_back(mk(0, 10'd254, 48'h800000000000, RNE, 0, 0, 0, 32'h7F800000, 1, 0)); // 1
        vecs.push_back(mk(0, 10'd254, 48'h800000000000, RTZ, 0, 0, 0, 32'h7F7FFFFF, 1, 0)); // 2
        vecs.push_back(mk(1, 10'd254, 48'h800000000000, RUP, 0, 0, 0, 32'hFF7FFFFF, 1, 0)); // 3
        vecs.push_back(mk(1, 10'd254, 48'h800000000000, RDN, 0, 0, 0, 32'hFF800000, 1, 0)); // 4
        vecs.push_back(mk(0, 10'd254, 48'h800000000000, RDN, 0, 0, 0, 32'h7F7FFFFF, 1, 0)); // 5
        vecs.push_back(mk(0, 10'd127, 48'h400000400000, RNE, 0, 0, 0, 32'h3F800000, 0, 0)); // 6
        vecs.push_back(mk(0, 10'd127, 48'h400000400000, RUP, 0, 0, 0, 32'h3F800001, 0, 0)); // 7
        vecs.push_back(mk(0, 10'd127, 48'h400000400000, RMM, 0, 0, 0, 32'h3F800001, 0, 0)); // 8
        vecs.push_back(mk(0, 10'd127, 48'h400000400000, RDN, 0, 0, 0, 32'h3F800000, 0, 0)); // 9
        vecs.push_back(mk(1, 10'd0,   48'h400000000000, RNE, 0, 0, 0, 32'h80000000, 0, 1)); // 10
        vecs.push_back(mk(1, 10'd0,   48'h400000000000, RNE, 1, 0, 0, 32'h7FC00000, 0, 0)); // 11
        vecs.push_back(mk(1, 10'd127, 48'h900000000000, RNE, 0, 1, 1, 32'hFF800000, 0, 0)); // 12
        vecs.push_back(mk(1, 10'd127, 48'h900000000000, RNE, 0, 0, 1, 32'h80000000, 0, 0)); // 13
        vecs.push_back(mk(0, 10'd127, 48'h900000000000, RNE, 1, 1, 0, 32'h7FC00000, 0, 0)); // 14
        vecs.push_back(mk(0, 10'd127, 48'h7FFFFFC00000, RNE, 0, 0, 0, 32'h40000000, 0, 0)); // 15
        vecs.push_back(mk(0, 10'd0,   48'h7FFFFFC00000, RNE, 0, 0, 0, 32'h00800000, 0, 0)); // 16
        vecs.push_back(mk(0, 10'h3FB, 48'h800000000000, RNE, 0, 0, 0, 32'h00000000, 0, 1)); // 17
        vecs.push_back(mk(0, 10'd127, 48'h400000C00000, RNE, 0, 0, 0, 32'h3F800002, 0, 0)); // 18
        vecs.push_back(mk(0, 10'd127, 48'h400000C00000, 3'b111, 0, 0, 0, 32'h3F800002, 0, 0)); // 19
        vecs.push_back(mk(0, 10'd127, 48'h400000C00000, RTZ, 0, 0, 0, 32'h3F800001, 0, 0)); // 20
        vecs.push_back(mk(1, 10'd127, 48'h400000000001, RDN, 0, 0, 0, 32'hBF800001, 0, 0)); // 21
        vecs.push_back(mk(1, 10'd127, 48'h400000000001, RUP, 0, 0, 0, 32'hBF800000, 0, 0)); // 22
        vecs.push_back(mk(0, 10'd253, 48'hFFFFFF800000, RNE, 0, 0, 0, 32'h7F800000, 1, 0)); // 23

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_fp_Z", bus.fp_Z, 0);
        chk("reset_ovrf", bus.ovrf, 0);
        chk("reset_udrf", bus.udrf, 0);

        foreach (vecs[i]) do_beat(vecs[i], i);

        // Backpressure: consumer stalls for 3 cycles while 4 beats are offered.
        bp[0] = vecs[0]; bp[1] = vecs[7]; bp[2] = vecs[2]; bp[3] = vecs[15];
        acc  = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 3);
            if (acc < 4) begin
                drive(bp[acc]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc < 3) chk($sformatf("bp_in_ready_c%0d", cyc), bus.in_ready, acc < 2);
            if (cyc == 2) chk("bp_out_valid_stalled", bus.out_valid, 1);
            if (bus.out_valid) begin
                chk($sformatf("bp_fp_Z_c%0d", cyc), bus.fp_Z, bp[recv].fp);
                chk($sformatf("bp_ovrf_c%0d", cyc), bus.ovrf, bp[recv].ov);
                if (bus.out_ready) recv++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
        end
        chk("bp_accepted", acc, 4);
        chk("bp_received", recv, 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset with both stages full: in-flight beats must vanish.
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[7]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("pre_rst_out_valid", bus.out_valid, 1);
        chk("pre_rst_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_fp_Z", bus.fp_Z, 0);
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rst_squashed", seen, 0);

        do_beat(vecs[18], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mul_round_stage.md
Name: fp_mul_round_stage

Overview:
- Downstream stage of the FP32 multiplier datapath.
- Consumes the raw 48-bit mantissa product `frc_Z_full`, the product sign, the pre-normalization exponent sum and special-case flags.
- Produces the normalized, rounded IEEE-754 single-precision `fp_Z` with `ovrf`/`udrf`.
- Two-stage pipeline (normalize, round) with valid/ready handshakes on both sides. Subnormal results flush to signed zero, consistent with the multiplier's flush-to-zero policy.

Parameters:
- `EXP_W`, 10, width of the signed exponent-sum input (holds `eX+eY-127`, range -125..381).
- `BIAS`, 127, FP32 exponent bias (used only for the `exp_max` constant; do not change).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `sign_Z`  in  1  product sign, `fp_X[31]^fp_Y[31]`.
- `exp_sum`  in  `EXP_W`  signed `eX+eY-127`.
- `frc_Z_full`  in  48  `{1,frc_X}*{1,frc_Y}`.
- `r_mode`  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others are treated as RNE.
- `is_nan`, `is_inf`, `is_zero`  in  1 each  special-case class from the operand classifier. Priority: nan > inf > zero.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `fp_Z`  out  32  rounded result.
- `ovrf`, `udrf`  out  1 each  overflow / underflow flags, valid with `out_valid`.

Behaviour:
- Reset: `s1_valid=0`, `s2_valid=0`, `out_valid=0`, `fp_Z=0`, `ovrf=0`, `udrf=0`. `in_ready=1` in the first cycle after reset. Reset mid-operation discards all in-flight beats; no output is produced for them.
- Handshake: a transfer occurs when valid&&ready.
  - `s2_adv = !s2_valid || out_ready`
  - `s1_adv = !s1_valid || s2_adv`
  - `in_ready = s1_adv` (combinational from `out_ready`, no skid buffer).
  - Latency is 2 cycles; throughput is 1/cycle when `out_ready=1`.
  - Output registers hold stable while `out_valid && !out_ready`.
  - Beats are delivered in order; none are dropped or duplicated.
- Stage 1 (normalize):
  - If `frc_Z_full[47]`: `man=frc[46:24]`, `g=frc[23]`, `st=|frc[22:0]`, `e=exp_sum+1`.
  - Else: `man=frc[45:23]`, `g=frc[22]`, `st=|frc[21:0]`, `e=exp_sum`.
  - Register `man`, `g`, `st`, `e`, sign, `r_mode` and the special flags.
- Stage 2 (round):
  - Increment `inc` by mode:
    - RNE: `g&(st|man[0])`
    - RTZ: 0
    - RDN: `(g|st)&sign`
    - RUP: `(g|st)&!sign`
    - RMM: `g`
  - `{c,m}=man+inc`. If `c`, then `e=e+1` and `m=0`.
- Stage 2 result classes, first match wins:
  - nan: `fp_Z=32'h7FC00000`, flags 0.
  - inf: `{sign,8'hFF,23'b0}`, flags 0.
  - zero: `{sign,31'b0}`, flags 0.
  - `e>=255` (overflow): `ovrf=1`. RNE/RMM give ±inf; RTZ gives ±`7F7FFFFF`; RDN gives +max / -inf; RUP gives +inf / -max.
  - `e<=0` (underflow): `{sign,31'b0}`, `udrf=1`. Evaluated after rounding; the exponent compare is signed.
  - Normal: `{sign,e[7:0],m}`.
- Simultaneous accept and emit in the same cycle is legal and must not stall.
- An unnormalized product (`frc[47:46]==00`) is a caller error. It is processed via the `frc[47]=0` path with no checking.

Decomposition:
- Package `fp_mul_pkg`:
  - `r_mode_e` enum (RNE, RTZ, RDN, RUP, RMM).
  - Constants `FP32_QNAN=32'h7FC00000`, `FP32_MAXF=31'h7F7FFFFF`, `EXP_MAX=8'hFE`.
  - Struct `norm_t {sign, e, man, g, st, r_mode, nan, inf, zero}` for the stage-1 register.
- One sub-module `fp_round_inc`: combinational increment decision from `(r_mode, sign, lsb, g, st)`. It is reused by the adder datapath.

Test Plan:
- `exp_sum=127`, `frc=48'h900000000000` (1.5*1.5), RNE, sign 0 -> `fp_Z=32'h40100000`, flags 0, `out_valid` exactly 2 cycles after accept.
- `exp_sum=254`, `frc=48'h800000000000` -> RNE gives `7F800000` with `ovrf=1`; RTZ gives `7F7FFFFF` with `ovrf=1`; sign 1 with RUP gives `FF7FFFFF`.
- Tie case: `exp_sum=127`, `frc=48'h400000400000` -> RNE `3F800000`; RUP `3F800001`; RMM `3F800001`; RDN `3F800000`; all flags 0.
- `exp_sum=0`, `frc=48'h400000000000`, sign 1 -> `fp_Z=32'h80000000`, `udrf=1`. With `is_nan=1` and the same data -> `7FC00000`, `udrf=0`.
- Backpressure: issue 4 back-to-back beats with `out_ready=0` for 3 cycles -> `in_ready` drops after 2 accepted, `fp_Z` stable while stalled, all 4 results emerge in order once `out_ready=1`.
- Assert `rst` for 1 cycle with both stages valid -> next cycle `out_valid=0`, `in_ready=1`, `fp_Z=0`, and the squashed beats never appear.
